// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter and burst sequencer for the shared
// memory command bus. One requester owns the bus at a time. Each granted
// burst is issued as one registered en/wr/addr beat per clock.
module mem_bus_arbiter #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [LEN_W-1:0]  len0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              en,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    logic              owner;       // requester that owns the current burst
    logic              last_gnt;    // requester granted most recently
    logic [LEN_W-1:0]  beats_left;  // beats still to issue after the current one

    logic              pick_vld;
    logic              pick;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic              last_beat;

    assign last_beat = (state == BURST) && (beats_left == '0);

    // Choose the next owner: in IDLE from any requester, on a last beat only
    // the other requester, so a finishing owner always sees an idle cycle.
    always_comb begin
        pick_vld = 1'b0;
        pick     = 1'b0;
        if (state == IDLE) begin
            if (req0 && req1) begin
                pick_vld = 1'b1;
                pick     = ~last_gnt;
            end else if (req0) begin
                pick_vld = 1'b1;
                pick     = 1'b0;
            end else if (req1) begin
                pick_vld = 1'b1;
                pick     = 1'b1;
            end
        end else if (last_beat) begin
            if (!owner && req1) begin
                pick_vld = 1'b1;
                pick     = 1'b1;
            end else if (owner && req0) begin
                pick_vld = 1'b1;
                pick     = 1'b0;
            end
        end
        sel_wr   = pick ? wr1   : wr0;
        sel_addr = pick ? addr1 : addr0;
        sel_len  = pick ? len1  : len0;
    end

    // Burst sequencer: latch the winner's command on grant, then step the
    // address once per beat and flag the final beat with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_gnt   <= 1'b1;
            beats_left <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            en         <= 1'b0;
            wr         <= 1'b0;
            addr       <= '0;
            busy       <= 1'b0;
        end else if (pick_vld) begin
            state      <= BURST;
            owner      <= pick;
            last_gnt   <= pick;
            beats_left <= sel_len;
            gnt0       <= ~pick;
            gnt1       <= pick;
            done0      <= ~pick && (sel_len == '0);
            done1      <= pick && (sel_len == '0);
            en         <= 1'b1;
            wr         <= sel_wr;
            addr       <= sel_addr;
            busy       <= 1'b1;
        end else if ((state == BURST) && !last_beat) begin
            beats_left <= beats_left - LEN_W'(1);
            addr       <= addr + ADDR_W'(1);
            done0      <= ~owner && (beats_left == LEN_W'(1));
            done1      <= owner && (beats_left == LEN_W'(1));
        end else begin
            state      <= IDLE;
            beats_left <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            en         <= 1'b0;
            wr         <= 1'b0;
            addr       <= '0;
            busy       <= 1'b0;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester, round-robin arbiter and burst sequencer for the shared memory command bus (en, wr, 6-bit addr).
- Each requester posts a burst: direction, base address and length. The block grants one requester at a time.
- For the granted burst it drives one en/wr/addr beat per posedge of clk, incrementing the address each beat.
- Sits between bench/traffic masters and the memory model; system clock is 25 MHz.

Parameters:
ADDR_W, 6, width of addr inputs and output
LEN_W, 3, width of burst length fields; length encodes beats-1 (max 2^LEN_W beats)

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  reset; asynchronous, active-high
req0  in  1  requester 0 burst request
wr0  in  1  requester 0 direction (1=write, 0=read)
addr0  in  ADDR_W  requester 0 base address
len0  in  LEN_W  requester 0 beats-1
req1  in  1  requester 1 burst request
wr1  in  1  requester 1 direction
addr1  in  ADDR_W  requester 1 base address
len1  in  LEN_W  requester 1 beats-1
gnt0  out  1  high during every beat of a requester 0 burst
gnt1  out  1  high during every beat of a requester 1 burst
done0  out  1  high on the last beat of a requester 0 burst
done1  out  1  high on the last beat of a requester 1 burst
en  out  1  bus enable, high on every beat
wr  out  1  bus direction for the current beat
addr  out  ADDR_W  bus address for the current beat
busy  out  1  high while a burst is in progress

Behaviour:
- Reset state, async on rst high:
  - All outputs 0; state IDLE.
  - Last-grant pointer = 1, so requester 0 wins the first tie.
- All outputs are registered.
- Latency: a request sampled at posedge k produces its first beat in the cycle following edge k.
- States:
  - IDLE: en=0, gnt*=0, busy=0.
  - BURST: owner latched, beat counter running.
- IDLE transitions, evaluated at each posedge:
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant it.
  - Both req high: grant the requester not named by the last-grant pointer.
  - On grant: latch the owner's wr, addr and len; set the pointer to the owner; go to BURST.
- BURST, per beat:
  - en=1; gnt_owner=1; busy=1.
  - wr = latched wr.
  - addr = base + beat index, modulo 2^ADDR_W (63 wraps to 0 for ADDR_W=6).
  - Burst length = len+1 beats. len=0 gives a single beat, with done on that beat.
- Last beat:
  - done_owner=1 for exactly that cycle.
  - At the edge ending the last beat, the just-finished owner's req is ignored.
  - If the other requester's req is high, grant it at that edge. Its first beat follows with no idle gap, and the pointer updates.
  - Otherwise go to IDLE.
  - A requester re-requesting therefore gets at least one idle cycle (en=0) before its next burst.
- Requester rules:
  - Hold req, wr, addr and len stable until gnt is seen.
  - Deassert req in the cycle done is seen, unless another burst is wanted.
  - Changes to wr/addr/len or req of the owner during BURST are ignored.
- gnt0 and gnt1 are never high together. done_x implies gnt_x.
- Reset mid-burst: outputs go to 0 immediately (asynchronous); the burst is abandoned with no done; pointer returns to 1.

Test Plan:
1. Single write: after reset, req0=1 wr0=1 addr0=12 len0=1 for one edge.
   - Two beats: en=1 wr=1 addr=12 then 13.
   - gnt0=1 on both beats; done0 only on the second.
   - Then en=0, busy=0.
2. Tie after reset: req0 (wr0=1 addr0=14 len0=0) and req1 (wr1=0 addr1=23 len1=1) high together.
   - Beat addr 14 with gnt0 and done0.
   - Next cycle, no gap: addr 23, 24 with wr=0 and gnt1; done1 on 24.
3. Wrap: req1 wr1=0 addr1=62 len1=3.
   - addr 62, 63, 0, 1; wr=0; done1 on addr 1.
4. Fairness: req0 and req1 held high continuously, len=0 both.
   - Grants alternate 0,1,0,1 with en high every cycle.
   - gnt0 and gnt1 never overlap.
5. Reset mid-burst: req0 addr0=48 len0=3; assert rst during the second beat (addr 49).
   - en, gnt0, done0 and busy drop to 0 immediately.
   - After release with req0 and req1 both high, requester 0 is granted first.
6. Same-requester repeat: only req0 held high, len0=1, addr0=56.
   - Beats 56, 57, then exactly one cycle en=0.
   - Then a new burst at 56, 57.
